// File: rtl/cfg_stride_counter.sv
// Configurable stride counter: counts start..limit (inclusive) by a programmable
// stride, in one-shot or wrap-around mode, with last/wrap/done status.
module cfg_stride_counter #(
    parameter int CNT_WIDTH  = 7,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [CNT_WIDTH-1:0]  start_val_i,
    input  logic [CNT_WIDTH-1:0]  limit_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic                  wrap_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  wrap_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [1:0]            state_dbg
);

    // Handshake: a beat is live while valid_o is high; it is consumed on any
    // clock edge where en_i is high, and the counter then advances.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  start_r, start_d;
    logic [CNT_WIDTH-1:0]  limit_r, limit_d;
    logic [STEP_WIDTH-1:0] step_r, step_d;
    logic                  wrap_mode_r, wrap_mode_d;

    logic [CNT_WIDTH:0]    step_ext;
    logic [CNT_WIDTH:0]    sum_ext;
    logic                  terminal;

    // One extra bit keeps cnt + step from aliasing back below the limit.
    assign step_ext = {{(CNT_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_r};
    assign sum_ext  = {1'b0, cnt_q} + step_ext;
    assign terminal = sum_ext > {1'b0, limit_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            start_r     <= '0;
            limit_r     <= '0;
            step_r      <= '0;
            wrap_mode_r <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            start_r     <= start_d;
            limit_r     <= limit_d;
            step_r      <= step_d;
            wrap_mode_r <= wrap_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        start_d     = start_r;
        limit_d     = limit_r;
        step_d      = step_r;
        wrap_mode_d = wrap_mode_r;

        if (clr_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            valid_d     = 1'b0;
            start_d     = '0;
            limit_d     = '0;
            step_d      = '0;
            wrap_mode_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        start_d     = start_val_i;
                        limit_d     = limit_i;
                        step_d      = (step_i == '0) ? STEP_WIDTH'(1) : step_i;
                        wrap_mode_d = wrap_i;
                        cnt_d       = start_val_i;
                        valid_d     = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (en_i) begin
                        if (!terminal) begin
                            cnt_d = sum_ext[CNT_WIDTH-1:0];
                        end else if (wrap_mode_r) begin
                            cnt_d  = start_r;
                            wrap_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign cnt_o     = cnt_q;
    assign valid_o   = valid_q;
    assign wrap_o    = wrap_q;
    assign done_o    = done_q;
    assign last_o    = (state_q == RUN) && terminal;
    assign busy_o    = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule
